// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank reader: default geometry and FSM states.
package reg_bank_pkg;

  localparam int W_DEF  = 4;
  localparam int N_DEF  = 4;
  localparam int AW_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/reg_bank_cell.sv
// One bank entry: W-bit register with write enable and asynchronous active-low clear.
module reg_bank_cell #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (we) data_d = d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= '0;
    else      data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/reg_bank_reader.sv
// Register bank with single-entry reads and a full sequential scan, all outputs registered.
//   state | meaning
//   IDLE  | accept rd_req / scan_start
//   SCAN  | present one entry per cycle, index 0..N-1
//   DONE  | one-cycle scan_done pulse, then back to IDLE
module reg_bank_reader
  import reg_bank_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  input  logic          scan_start,
  output logic          rd_valid,
  output logic [W-1:0]  rd_data,
  output logic [AW-1:0] rd_idx,
  output logic          busy,
  output logic          scan_done
);

  logic [N-1:0]  we_dec;
  logic [W-1:0]  bank [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_cell
    assign we_dec[gi] = wen && (waddr == AW'(gi));

    reg_bank_cell #(.W(W)) u_cell (
      .clk (clk),
      .rst (rst),
      .we  (we_dec[gi]),
      .d   (wdata),
      .q   (bank[gi])
    );
  end

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          rd_valid_q, rd_valid_d;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic          busy_q, busy_d;
  logic          scan_done_q, scan_done_d;

  logic [AW-1:0] sel_addr;
  logic [W-1:0]  fwd_data;

  // Address of the entry registered on this edge: scan start, next scan entry, or single read.
  always_comb begin
    sel_addr = rd_addr;
    if (state_q == IDLE && scan_start) sel_addr = '0;
    else if (state_q == SCAN)          sel_addr = idx_q + AW'(1);
  end

  // A write landing on the same edge wins over the stored value.
  assign fwd_data = (wen && (waddr == sel_addr)) ? wdata : bank[sel_addr];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    rd_idx_d    = rd_idx_q;
    busy_d      = busy_q;
    scan_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (scan_start) begin
          state_d    = SCAN;
          idx_d      = '0;
          busy_d     = 1'b1;
          rd_valid_d = 1'b1;
          rd_idx_d   = sel_addr;
          rd_data_d  = fwd_data;
        end else if (rd_req) begin
          rd_valid_d = 1'b1;
          rd_idx_d   = sel_addr;
          rd_data_d  = fwd_data;
        end
      end
      SCAN: begin
        busy_d = 1'b1;
        if (idx_q == AW'(N - 1)) begin
          state_d     = DONE;
          idx_d       = '0;
          scan_done_d = 1'b1;
        end else begin
          idx_d      = sel_addr;
          rd_valid_d = 1'b1;
          rd_idx_d   = sel_addr;
          rd_data_d  = fwd_data;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_idx_q    <= '0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_idx_q    <= rd_idx_d;
      busy_q      <= busy_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_idx    = rd_idx_q;
  assign busy      = busy_q;
  assign scan_done = scan_done_q;

endmodule

// File: tb/tb_reg_bank_reader.sv
// Scoreboard bench for reg_bank_reader (W=4, N=4): reads, forwarding, scans, and reset mid-scan.
module tb_reg_bank_reader;

  logic       clk;
  logic       rst;
  logic       wen;
  logic [1:0] waddr;
  logic [3:0] wdata;
  logic       rd_req;
  logic [1:0] rd_addr;
  logic       scan_start;
  logic       rd_valid;
  logic [3:0] rd_data;
  logic [1:0] rd_idx;
  logic       busy;
  logic       scan_done;

  reg_bank_reader #(.W(4), .N(4), .AW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .scan_start (scan_start),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_idx     (rd_idx),
    .busy       (busy),
    .scan_done  (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] idx;
    logic [3:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] model [4];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    wen = 1'b0; waddr = '0; wdata = '0;
    rd_req = 1'b0; rd_addr = '0; scan_start = 1'b0;
  endtask

  // Drive one cycle of stimulus; when accept is set, push what the DUT should produce.
  task automatic drive(input bit we, input logic [1:0] wa, input logic [3:0] wd,
                       input bit rr, input logic [1:0] ra, input bit ss, input bit accept);
    exp_t e;
    @(negedge clk);
    wen = we; waddr = wa; wdata = wd;
    rd_req = rr; rd_addr = ra; scan_start = ss;
    if (we) model[wa] = wd;
    if (accept) begin
      if (ss) begin
        for (int i = 0; i < 4; i++) begin
          e.idx = 2'(i); e.data = model[i];
          sb.push_back(e);
        end
      end else if (rr) begin
        e.idx = ra; e.data = model[ra];
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  // Called right after the scan_start edge: expects N busy cycles, DONE pulse, then idle.
  task automatic check_scan_timing(input string tag);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      check({tag, "_busy"}, busy, 1);
      check({tag, "_valid"}, rd_valid, 1);
      check({tag, "_nodone"}, scan_done, 0);
    end
    @(posedge clk); #1;
    check({tag, "_done"}, scan_done, 1);
    check({tag, "_done_novalid"}, rd_valid, 0);
    check({tag, "_done_busy"}, busy, 1);
    @(posedge clk); #1;
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_done"}, scan_done, 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rd_valid", rd_valid, 0);
      end else begin
        e = sb.pop_front();
        check("rd_idx", rd_idx, e.idx);
        check("rd_data", rd_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] vals [4];
    vals[0] = 4'h3; vals[1] = 4'h5; vals[2] = 4'hA; vals[3] = 4'hC;
    for (int i = 0; i < 4; i++) model[i] = '0;
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", rd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", scan_done, 0);
    check("rst_data", rd_data, 0);
    check("rst_idx", rd_idx, 0);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) drive(1, 2'(i), vals[i], 0, 0, 0, 0);

    drive(0, 0, 0, 1, 2, 0, 1);
    check("read2_valid", rd_valid, 1);
    check("read2_data", rd_data, 4'hA);

    drive(0, 0, 0, 1, 0, 0, 1);
    drive(0, 0, 0, 1, 3, 0, 1);
    drive(0, 0, 0, 1, 1, 0, 1);
    @(posedge clk); #1;
    check("hold_valid", rd_valid, 0);
    check("hold_data", rd_data, 4'h5);
    check("hold_idx", rd_idx, 1);

    drive(1, 1, 4'h9, 1, 1, 0, 1);
    check("fwd_data", rd_data, 4'h9);
    drive(1, 2, 4'h6, 1, 3, 0, 1);
    drive(1, 1, 4'h5, 0, 0, 0, 0);
    drive(1, 2, 4'hA, 0, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 1, 1);
    check_scan_timing("scan");

    drive(0, 0, 0, 1, 2, 1, 1);
    check_scan_timing("scan_prio");

    drive(0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 3, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 0);
    check("busy_drop_done", scan_done, 1);
    @(posedge clk); #1;
    check("busy_drop_idle", busy, 0);
    repeat (3) @(posedge clk);
    #1;

    drive(0, 0, 0, 0, 0, 1, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_scan_idx", rd_idx, 2);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", rd_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_data", rd_data, 0);
    check("arst_idx", rd_idx, 0);
    sb.delete();
    for (int i = 0; i < 4; i++) model[i] = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    rd_req = 1'b1; rd_addr = 2'd2;
    sb.push_back('{idx: 2'd2, data: 4'h0});
    #1;
    check("rel_valid", rd_valid, 0);
    check("rel_done", scan_done, 0);
    @(posedge clk); #1;
    clear_inputs();
    check("rel_read_valid", rd_valid, 1);
    check("rel_nodone", scan_done, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 2'(i), 0, 1);
    repeat (3) begin
      @(posedge clk); #1;
      check("post_nodone", scan_done, 0);
    end
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_reader.md
REG_BANK_READER -- requirements
Module: reg_bank_reader

Interface
REQ-001 Parameter W, default 4: data width of every entry.
REQ-002 Parameter N, default 4: number of entries; a power of two, at least 2.
REQ-003 Parameter AW, default 2: address width, equal to log2(N).
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 rst  in  1: reset, asynchronous, active-low.
REQ-006 wen  in  1: write enable for the bank.
REQ-007 waddr  in  AW: write address.
REQ-008 wdata  in  W: write data.
REQ-009 rd_req  in  1: single-entry read request.
REQ-010 rd_addr  in  AW: read address, sampled with rd_req.
REQ-011 scan_start  in  1: request to dump all N entries in sequence.
REQ-012 rd_valid  out  1: rd_data and rd_idx are valid this cycle.
REQ-013 rd_data  out  W: read result.
REQ-014 rd_idx  out  AW: address of the entry presented on rd_data.
REQ-015 busy  out  1: high in SCAN and DONE; requests are ignored while it is high.
REQ-016 scan_done  out  1: one-cycle pulse marking the end of a scan.

Function
REQ-017 Write: on each edge with wen=1, bank[waddr] SHALL take wdata; with wen=0 every entry SHALL hold its value. Writes SHALL be accepted in every FSM state.
REQ-018 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-019 IDLE with scan_start=1 SHALL go to SCAN, load the scan index with 0 and ignore rd_req on that edge. scan_start has priority over rd_req.
REQ-020 IDLE with rd_req=1 and scan_start=0: on the next cycle rd_valid SHALL be 1, rd_idx SHALL equal rd_addr and rd_data SHALL equal bank[rd_addr]. Read latency is 1 cycle.
REQ-021 Back-to-back rd_req in IDLE SHALL give rd_valid on consecutive cycles, one result per request, in request order.
REQ-022 SCAN SHALL present one entry per cycle on rd_data/rd_idx with rd_valid=1, for indices 0, 1, ... N-1 in order. After index N-1 the FSM SHALL go to DONE.
REQ-023 DONE SHALL last one cycle with scan_done=1 and rd_valid=0, then return to IDLE.
REQ-024 Forwarding: if a write hits the same address as the read or scan entry sampled on that edge, the registered rd_data SHALL be the new wdata, not the old content.
REQ-025 rd_req and scan_start SHALL be dropped, not queued, while busy=1.
REQ-026 A scan from IDLE to IDLE SHALL take exactly N+1 cycles. The scan index SHALL wrap from N-1 to 0 without overflow.
REQ-027 rd_valid, rd_data, rd_idx, busy and scan_done SHALL all be registered outputs.
REQ-028 When rd_valid=0, rd_data and rd_idx SHALL hold their last values.

Reset
REQ-029 rst=0 SHALL, asynchronously: clear all entries to 0, put the FSM in IDLE, clear the scan index, and drive rd_valid, busy and scan_done to 0 and rd_data and rd_idx to 0.
REQ-030 Reset during SCAN SHALL end the scan at once: no scan_done pulse and no rd_valid in the first cycle after release.
REQ-031 In the first cycle after rst rises, requests SHALL be accepted normally.

Structure
REQ-032 Package reg_bank_pkg SHALL hold the FSM state enumeration (IDLE, SCAN, DONE) and the default values of W, N and AW.
REQ-033 Each entry SHALL be one instance of sub-module reg_bank_cell: a W-bit register with write enable and asynchronous active-low clear.
REQ-034 reg_bank_reader SHALL contain the address decode, the read mux with forwarding, and the FSM.

Verification (W=4, N=4)
REQ-035 Write 0x3,0x5,0xA,0xC to addresses 0..3, then rd_req addr=2 -> next cycle rd_valid=1, rd_idx=2, rd_data=0xA.
REQ-036 rd_req addr=1 in the same cycle as wen=1, waddr=1, wdata=0x9 -> next cycle rd_data=0x9.
REQ-037 scan_start with bank {3,5,A,C} -> four cycles of rd_valid with idx 0..3 and data 3,5,A,C, then scan_done for 1 cycle, then busy=0; total 5 cycles.
REQ-038 rd_req and scan_start together in IDLE -> a scan runs; no single-read result appears.
REQ-039 rd_req pulsed during SCAN -> ignored, no extra rd_valid after DONE.
REQ-040 rst=0 at scan index 2 -> outputs go to 0 at once, the bank reads back 0, and there is no scan_done pulse.
